// File: rtl/display_scan_ctrl_pkg.sv
// Shared widths and digit helpers for the seven-segment scan controller.
package scan_pkg;

   localparam int DIGIT_W    = 4;
   localparam int IDX_W      = 3;
   localparam int MAX_DIGITS = 8;
   localparam int DIV_W      = 20;
   localparam int VAL_W      = MAX_DIGITS * DIGIT_W;

   // Hex nibble of digit idx within a packed display value.
   function automatic logic [DIGIT_W-1:0] nibble_of(input logic [VAL_W-1:0] value,
                                                    input logic [IDX_W-1:0] idx);
      return value[{idx, 2'b00} +: DIGIT_W];
   endfunction

   // Digit idx is a leading zero when it and every higher active digit are 0.
   // Digit 0 always shows, so an all-zero value still displays a single "0".
   function automatic logic lz_blank(input logic [VAL_W-1:0] value,
                                     input logic [IDX_W-1:0] idx,
                                     input int ndig);
      logic b;
      b = (idx != '0);
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i >= int'(idx) && i < ndig && value[i*DIGIT_W +: DIGIT_W] != '0)
            b = 1'b0;
      end
      return b;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Control/data bundle between the scan controller and its host/display side.
interface display_scan_ctrl_if;
   import scan_pkg::*;

   logic                EN;
   logic                LD;
   logic [VAL_W-1:0]    DIN;
   logic                BLANK_LZ;
   logic [IDX_W-1:0]    SEL;
   logic [DIGIT_W-1:0]  NIBBLE;
   logic                BLANK;
   logic                FRAME;
   logic                BUSY;

   modport master (
      output EN, LD, DIN, BLANK_LZ,
      input  SEL, NIBBLE, BLANK, FRAME, BUSY
   );

   modport slave (
      input  EN, LD, DIN, BLANK_LZ,
      output SEL, NIBBLE, BLANK, FRAME, BUSY
   );

endinterface

// File: rtl/display_scan_ctrl_prescaler.sv
// Divides CP down to a one-cycle scan tick every DIV enabled cycles.
module scan_prescaler
   import scan_pkg::*;
#(
   parameter int DIV = 50000
) (
   input  logic CP,
   input  logic CLR,
   input  logic i_en,
   output logic o_tick
);

   localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] r_cnt;
   logic             w_tick;

   assign w_tick = i_en && (r_cnt == TERM);
   assign o_tick = w_tick;

   // Count 0..DIV-1 while enabled; hold when disabled.
   always_ff @(posedge CP or posedge CLR) begin
      if (CLR)         r_cnt <= '0;
      else if (w_tick) r_cnt <= '0;
      else if (i_en)   r_cnt <= r_cnt + DIV_W'(1);
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan controller: steps the decoder index, double-buffers the display
// value with frame-boundary swaps, and registers nibble/blank one cycle behind
// SEL to line up with the decoder's registered output.
module display_scan_ctrl
   import scan_pkg::*;
#(
   parameter int DIV        = 50000,
   parameter int NUM_DIGITS = 8
) (
   input  logic               CP,
   input  logic               CLR,
   display_scan_ctrl_if.slave bus
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

   logic               w_tick;
   logic               w_wrap;
   logic [IDX_W-1:0]   r_sel;
   logic               r_frame;
   logic [VAL_W-1:0]   r_pending;
   logic [VAL_W-1:0]   r_shadow;
   logic               r_busy;
   logic [DIGIT_W-1:0] r_nibble;
   logic               r_blank;

   scan_prescaler #(.DIV(DIV)) u_presc (
      .CP     (CP),
      .CLR    (CLR),
      .i_en   (bus.EN),
      .o_tick (w_tick)
   );

   assign w_wrap = w_tick && (r_sel == LAST);

   // Digit index stepping; FRAME marks the cycle SEL returns to 0.
   always_ff @(posedge CP or posedge CLR) begin
      if (CLR) begin
         r_sel   <= '0;
         r_frame <= 1'b0;
      end else begin
         r_frame <= w_wrap;
         if (w_wrap)      r_sel <= '0;
         else if (w_tick) r_sel <= r_sel + IDX_W'(1);
      end
   end

   // Double buffer: a new value waits in pending and moves to shadow only on
   // a wrap tick; a load landing exactly on the wrap goes straight to shadow.
   always_ff @(posedge CP or posedge CLR) begin
      if (CLR) begin
         r_pending <= '0;
         r_shadow  <= '0;
         r_busy    <= 1'b0;
      end else if (bus.LD && w_wrap) begin
         r_shadow  <= bus.DIN;
         r_busy    <= 1'b0;
      end else if (w_wrap && r_busy) begin
         r_shadow  <= r_pending;
         r_busy    <= 1'b0;
      end else if (bus.LD) begin
         r_pending <= bus.DIN;
         r_busy    <= 1'b1;
      end
   end

   // Output pipeline: digit data for the current SEL, visible one cycle later.
   always_ff @(posedge CP or posedge CLR) begin
      if (CLR) begin
         r_nibble <= '0;
         r_blank  <= 1'b0;
      end else begin
         r_nibble <= nibble_of(r_shadow, r_sel);
         r_blank  <= bus.BLANK_LZ && lz_blank(r_shadow, r_sel, NUM_DIGITS);
      end
   end

   assign bus.SEL    = r_sel;
   assign bus.FRAME  = r_frame;
   assign bus.BUSY   = r_busy;
   assign bus.NIBBLE = r_nibble;
   assign bus.BLANK  = r_blank;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: DIV=4/8 digits main instance plus a
// DIV=1/1 digit corner instance sharing the clock and reset.
module tb_display_scan_ctrl;

   logic CP;
   logic CLR;
   int   n_chk;
   int   n_fail;

   display_scan_ctrl_if bus_a ();
   display_scan_ctrl_if bus_b ();

   display_scan_ctrl #(.DIV(4), .NUM_DIGITS(8)) dut_a (
      .CP  (CP),
      .CLR (CLR),
      .bus (bus_a)
   );

   display_scan_ctrl #(.DIV(1), .NUM_DIGITS(1)) dut_b (
      .CP  (CP),
      .CLR (CLR),
      .bus (bus_b)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CP);
      #1;
   endtask

   // Advance until FRAME is seen on the main instance, bounded.
   task automatic wait_frame();
      logic found;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         if (bus_a.FRAME === 1'b1) found = 1'b1;
      end
      chk("frame_seen", {31'd0, found}, 32'd1);
   endtask

   task automatic load_a(input logic [31:0] v);
      bus_a.DIN = v;
      bus_a.LD  = 1'b1;
      step();
      bus_a.LD  = 1'b0;
   endtask

   // Main instance: index after m steps from a frame sample (DIV=4, 8 digits).
   function automatic int sel_at(input int m);
      return (m / 4) % 8;
   endfunction

   function automatic logic [3:0] dig(input logic [31:0] v, input int k);
      logic [31:0] t;
      t = v >> (4 * k);
      return t[3:0];
   endfunction

   initial begin
      n_chk  = 0;
      n_fail = 0;
      CLR    = 1'b1;
      bus_a.EN = 1'b1; bus_a.LD = 1'b0; bus_a.DIN = '0; bus_a.BLANK_LZ = 1'b0;
      bus_b.EN = 1'b1; bus_b.LD = 1'b0; bus_b.DIN = '0; bus_b.BLANK_LZ = 1'b1;
      repeat (2) step();

      // Reset state
      chk("rst_sel",    32'(bus_a.SEL),    32'd0);
      chk("rst_nibble", 32'(bus_a.NIBBLE), 32'd0);
      chk("rst_blank",  32'(bus_a.BLANK),  32'd0);
      chk("rst_frame",  32'(bus_a.FRAME),  32'd0);
      chk("rst_busy",   32'(bus_a.BUSY),   32'd0);
      chk("rst_sel_b",  32'(bus_b.SEL),    32'd0);
      CLR = 1'b0;

      // Index stepping and frame pulse from reset
      for (int n = 1; n <= 36; n++) begin
         step();
         chk("scan_sel",   32'(bus_a.SEL),   32'(sel_at(n)));
         chk("scan_frame", 32'(bus_a.FRAME), (n % 32 == 0) ? 32'd1 : 32'd0);
      end

      // Pipeline alignment
      bus_a.BLANK_LZ = 1'b1;
      load_a(32'h87654321);
      chk("pipe_busy", 32'(bus_a.BUSY), 32'd1);
      wait_frame();
      chk("pipe_busy_clr", 32'(bus_a.BUSY), 32'd0);
      for (int m = 1; m <= 32; m++) begin
         step();
         chk("pipe_nibble", 32'(bus_a.NIBBLE), 32'(sel_at(m - 1) + 1));
         chk("pipe_blank",  32'(bus_a.BLANK),  32'd0);
      end

      // Tear-free swap: shadow = 1s, queue A then B mid-frame
      load_a(32'h11111111);
      wait_frame();
      repeat (8) step();                          // SEL=2
      chk("tear_sel2", 32'(bus_a.SEL), 32'd2);
      load_a(32'hAAAAAAAA);                       // m=9
      chk("tear_busy_a", 32'(bus_a.BUSY), 32'd1);
      repeat (11) step();                         // m=20, SEL=5
      chk("tear_sel5", 32'(bus_a.SEL), 32'd5);
      load_a(32'hBBBBBBBB);                       // m=21
      chk("tear_nib21", 32'(bus_a.NIBBLE), 32'h1);
      for (int m = 22; m <= 31; m++) begin
         step();
         chk("tear_old_nib", 32'(bus_a.NIBBLE), 32'h1);
         chk("tear_busy",    32'(bus_a.BUSY),   32'd1);
      end
      step();                                     // m=32, wrap
      chk("tear_frame",    32'(bus_a.FRAME),  32'd1);
      chk("tear_busy_end", 32'(bus_a.BUSY),   32'd0);
      chk("tear_last_old", 32'(bus_a.NIBBLE), 32'h1);
      for (int m = 1; m <= 32; m++) begin
         step();
         chk("tear_new_nib", 32'(bus_a.NIBBLE), 32'hB);
      end

      // LD coincident with wrap tick
      chk("cafe_frame0", 32'(bus_a.FRAME), 32'd1);
      repeat (31) step();
      chk("cafe_sel7", 32'(bus_a.SEL), 32'd7);
      load_a(32'h0000CAFE);
      chk("cafe_frame", 32'(bus_a.FRAME), 32'd1);
      chk("cafe_sel0",  32'(bus_a.SEL),   32'd0);
      chk("cafe_busy0", 32'(bus_a.BUSY),  32'd0);
      for (int m = 1; m <= 8; m++) begin
         step();
         chk("cafe_nib",  32'(bus_a.NIBBLE), 32'(dig(32'h0000CAFE, sel_at(m - 1))));
         chk("cafe_busy", 32'(bus_a.BUSY),   32'd0);
      end

      // Leading-zero blanking
      load_a(32'h00000F00);
      wait_frame();
      for (int m = 1; m <= 32; m++) begin
         step();
         chk("lz_nib",   32'(bus_a.NIBBLE), 32'(dig(32'h00000F00, sel_at(m - 1))));
         chk("lz_blank", 32'(bus_a.BLANK),  (sel_at(m - 1) >= 3) ? 32'd1 : 32'd0);
      end
      load_a(32'h00000000);
      wait_frame();
      for (int m = 1; m <= 32; m++) begin
         step();
         chk("z_nib",   32'(bus_a.NIBBLE), 32'd0);
         chk("z_blank", 32'(bus_a.BLANK),  (sel_at(m - 1) != 0) ? 32'd1 : 32'd0);
      end

      // EN freeze mid-count: SEL=1 with prescaler at 2
      repeat (6) step();
      chk("frz_sel_pre", 32'(bus_a.SEL), 32'd1);
      bus_a.EN = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("frz_sel",   32'(bus_a.SEL),   32'd1);
         chk("frz_frame", 32'(bus_a.FRAME), 32'd0);
      end
      bus_a.EN = 1'b1;
      step();
      chk("frz_resume1", 32'(bus_a.SEL), 32'd1);
      step();
      chk("frz_resume2", 32'(bus_a.SEL), 32'd2);

      // Async clear at SEL=5 with a pending value
      load_a(32'h12345678);
      chk("clr_busy_pre", 32'(bus_a.BUSY), 32'd1);
      repeat (11) step();
      chk("clr_sel5", 32'(bus_a.SEL), 32'd5);
      CLR = 1'b1;
      #2;
      chk("clr_sel",    32'(bus_a.SEL),    32'd0);
      chk("clr_busy",   32'(bus_a.BUSY),   32'd0);
      chk("clr_nibble", 32'(bus_a.NIBBLE), 32'd0);
      #1;
      CLR = 1'b0;
      wait_frame();
      chk("clr_busy_post", 32'(bus_a.BUSY), 32'd0);
      step();
      chk("clr_discard", 32'(bus_a.NIBBLE), 32'd0);

      // Single digit, DIV=1
      for (int i = 0; i < 3; i++) begin
         step();
         chk("b_sel",   32'(bus_b.SEL),   32'd0);
         chk("b_frame", 32'(bus_b.FRAME), 32'd1);
      end
      bus_b.EN = 1'b0;
      step();
      chk("b_en0_frame", 32'(bus_b.FRAME), 32'd0);
      chk("b_en0_sel",   32'(bus_b.SEL),   32'd0);
      bus_b.EN = 1'b1;
      step();
      chk("b_en1_frame", 32'(bus_b.FRAME), 32'd1);
      bus_b.DIN = 32'h00000007;
      bus_b.LD  = 1'b1;
      step();
      bus_b.LD  = 1'b0;
      chk("b_busy", 32'(bus_b.BUSY), 32'd0);
      step();
      chk("b_nibble", 32'(bus_b.NIBBLE), 32'h7);
      chk("b_blank",  32'(bus_b.BLANK),  32'd0);
      chk("b_busy2",  32'(bus_b.BUSY),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Upstream feeder for the clocked 3-to-8 one-hot digit decoder on the 8-digit seven-segment display. It prescales CP down to a scan tick and steps a 3-bit digit index that drives the decoder's 3-bit DATA input. It also supplies the matching 4-bit hex nibble and a blank flag to the segment encoder. A 32-bit display value is double-buffered and swapped only at frame boundaries, so the display never tears.

Parameters:
DIV, 50000, prescaler terminal count; one scan tick every DIV enabled CP cycles; legal 1..2^20
NUM_DIGITS, 8, number of active digits; index wraps at NUM_DIGITS-1; legal 1..8

Ports:
CP  input  1  system clock, rising edge
CLR  input  1  asynchronous active-high reset
EN  input  1  scan enable; low freezes prescaler and index
LD  input  1  load strobe; captures DIN
DIN  input  32  display value, digit k = DIN[4k+3:4k]
BLANK_LZ  input  1  enable leading-zero blanking
SEL  output  3  digit index; wire to decoder DATA
NIBBLE  output  4  hex value of the digit addressed by SEL one cycle earlier
BLANK  output  1  blank flag aligned with NIBBLE
FRAME  output  1  one-cycle pulse on index wrap
BUSY  output  1  a loaded value is pending, not yet displayed

Behaviour:
- Interface: one clock, CP. Reset CLR is asynchronous and active-high.
- Reset state: prescaler=0, SEL=0, NIBBLE=0, BLANK=0, FRAME=0, shadow=0, pending=0, BUSY=0. CLR asserted mid-frame aborts the frame immediately. Any pending value is discarded.
- Prescaler: counts 0..DIV-1 while EN=1. tick=1 when count==DIV-1 and EN=1; the count then returns to 0. DIV=1 gives a tick every enabled cycle.
- EN=0: prescaler, SEL and FRAME hold. FRAME is forced to 0. LD still captures.
- Index: on tick, SEL <= (SEL==NUM_DIGITS-1) ? 0 : SEL+1. With NUM_DIGITS=1, SEL stays 0 and every tick is a wrap.
- FRAME=1 for exactly the cycle after a wrap tick, i.e. coincident with SEL becoming 0.
- Load handshake:
  - LD=1 captures DIN into pending and sets BUSY=1 next cycle.
  - Repeated LD before the swap overwrites pending; last value wins.
  - On a wrap tick with BUSY=1: shadow <= pending, BUSY <= 0.
  - LD coincident with a wrap tick: DIN loads straight into shadow and BUSY=0.
  - LD with BUSY=0 and no tick: normal capture.
- Data pipeline: NIBBLE <= shadow[4*SEL+:4] and BLANK <= blank(SEL, shadow), both registered from the current-cycle SEL and shadow. NIBBLE and BLANK therefore lag SEL by exactly one CP cycle, matching the decoder's one-cycle registered latency.
- Blanking: blank(i) = BLANK_LZ && i!=0 && every nibble i..NUM_DIGITS-1 of shadow is 0. Digit 0 is never blanked, so value 0 shows a single "0".
- SEL never exceeds NUM_DIGITS-1.

Decomposition:
- Package scan_pkg holds:
  - DIGIT_W=4
  - IDX_W=3
  - MAX_DIGITS=8
  - DIV_W=20
  - function nibble_of(value, idx)
  - function lz_blank(value, idx, ndig)
- One natural sub-module: scan_prescaler (CP, CLR, EN, DIV parameter -> tick). Index, buffering and output pipeline stay in the top block.

Test Plan:
- Reset: hold CLR, then release with EN=1, DIV=4, NUM_DIGITS=8. SEL steps 0,1,...,7,0, one step every 4 CP cycles. FRAME pulses once per 32 cycles, aligned to SEL=0.
- Pipeline alignment: load DIN=32'h87654321. Each cycle after SEL=k, NIBBLE=k+1, so SEL=3 is followed one cycle later by NIBBLE=4. BLANK stays 0 throughout.
- Tear-free swap: while shadow=32'h11111111, pulse LD with DIN=32'hAAAAAAAA at SEL=2, then LD with DIN=32'hBBBBBBBB at SEL=5. BUSY=1 until the wrap. Digits 3..7 still show 1. After the wrap every digit shows B and BUSY=0.
- LD coincident with wrap tick, DIN=32'h0000CAFE: SEL=0 shows E on the next cycle, and BUSY never rises.
- Leading zeros: DIN=32'h00000F00 with BLANK_LZ=1. BLANK=1 for SEL 3..7 and 0 for SEL 0..2. With DIN=0, only digit 0 is unblanked, with NIBBLE=0.
- Boundaries:
  - EN low for 10 cycles mid-count: SEL and prescaler frozen, then resume exactly where they stopped.
  - CLR pulsed at SEL=5 with BUSY=1: SEL=0 and BUSY=0 asynchronously.
  - NUM_DIGITS=1, DIV=1: SEL=0 constant and FRAME high every enabled cycle.
